// File: rtl/uart_pkg.sv
// Definitions shared by uart_tx and UART_rx: FSM states, line timing and parity helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int CLK_HZ = 5_000_000;
    localparam int BAUD   = 4800;
    // 5 MHz / 4800 baud = 1041.67, rounded to the nearest whole clock.
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

    localparam logic PARITY_SEL_EVEN = 1'b0;
    localparam logic PARITY_SEL_ODD  = 1'b1;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign tick_o  = at_last && !clear_i;

    always_comb begin
        // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q + 1'b1;
        if (clear_i || at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first as start, data, parity, stop.
module uart_tx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 Rs232_tx,
    output logic                 busy,
    output logic                 done_flag
);

    import uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic PAR_SEL = (PARITY_ODD != 0) ? PARITY_SEL_ODD : PARITY_SEL_EVEN;

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 parity_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 baud_clear;
    logic                 bit_tick;

    // Holding the counter in IDLE makes the first bit start exactly one cycle after the handshake.
    assign baud_clear = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .clear_i(baud_clear),
        .tick_o (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q  <= tx_data;
                        parity_q <= calc_parity(8'(tx_data), PAR_SEL);
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt_q == LAST_STOP) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready  = ready_q;
    assign busy      = busy_q;
    assign Rs232_tx  = tx_q;
    assign done_flag = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames on three instances plus random traffic on a fast fourth.
module tb_uart_tx;

    localparam int NDUT = 4;
    localparam int N    = 1042;
    localparam int CPB_P [NDUT] = '{1042, 1042, 1042, 3};
    localparam int DB_P  [NDUT] = '{8, 8, 8, 6};
    localparam int PE_P  [NDUT] = '{0, 1, 1, 1};
    localparam int PO_P  [NDUT] = '{0, 0, 1, 1};
    localparam int SB_P  [NDUT] = '{1, 1, 1, 2};

    typedef logic [11:0][NDUT-1:0] samp_t;

    logic            clk = 1'b0;
    logic [NDUT-2:0] rst_m;
    logic [NDUT-2:0] valid_m;
    logic [7:0]      data_m;
    logic            rnd_rst;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    bit              rnd_run = 1'b1;
    bit              mon_en  = 1'b0;
    int              rnd_frames = 0;
    int              n_checks = 0;
    int              n_errors = 0;

    wire [NDUT-1:0] rst      = {rnd_rst, rst_m};
    wire [NDUT-1:0] tx_valid = {rnd_valid, valid_m};
    logic [NDUT-1:0] tx_ready;
    logic [NDUT-1:0] line;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
            if (n_errors >= 20) begin
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $finish;
            end
        end
    endtask

    // Line levels of one frame, index 0 = start bit; unused upper positions stay high.
    function automatic logic [11:0] build_frame(input logic [7:0] d, input int db,
                                                input int pe, input int po);
        logic [11:0] f;
        logic        p;
        f = '1;
        f[0] = 1'b0;
        p = (po != 0);
        for (int i = 0; i < db; i++) begin
            f[1+i] = d[i];
            p ^= d[i];
        end
        if (pe != 0) f[1+db] = p;
        return f;
    endfunction

    function automatic logic [11:0] col(input samp_t s, input int g);
        logic [11:0] c;
        for (int i = 0; i < 12; i++) c[i] = s[i][g];
        return c;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CPB  = CPB_P[g];
        localparam int DB   = DB_P[g];
        localparam int FLEN = 1 + DB + PE_P[g] + SB_P[g];
        wire [7:0] din = (g == NDUT - 1) ? rnd_data : data_m;

        uart_tx #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY_EN   (PE_P[g]),
            .PARITY_ODD  (PO_P[g]),
            .STOP_BITS   (SB_P[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .tx_data  (din[DB-1:0]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .Rs232_tx (line[g]),
            .busy     (busy[g]),
            .done_flag(done[g])
        );

        // Reference: after a handshake the line shows frame bit (m / CPB) for FLEN*CPB cycles.
        bit          active   = 1'b0;
        bit          done_exp = 1'b0;
        int          m        = 0;
        logic [11:0] fbits    = '1;

        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                active   = 1'b0;
                done_exp = 1'b0;
            end else begin
                done_exp = 1'b0;
                if (active) begin
                    m++;
                    if (m == FLEN * CPB) begin
                        active   = 1'b0;
                        done_exp = 1'b1;
                    end
                end else if (tx_valid[g]) begin
                    fbits  = build_frame(din, DB, PE_P[g], PO_P[g]);
                    active = 1'b1;
                    m      = 0;
                end
            end
        end

        always @(negedge clk) begin
            if (mon_en) begin
                logic exp_line;
                exp_line = active ? fbits[m / CPB] : 1'b1;
                check($sformatf("u%0d.out", g),
                      32'({line[g], tx_ready[g], busy[g], done[g]}),
                      32'({exp_line, !active, active, done_exp}));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic handshake(input logic [2:0] mask, input logic [7:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        data_m  = d;
        valid_m = valid_m | mask;
        for (int i = 0; i < 4 * N && !ok; i++) begin
            ok = ((tx_ready[2:0] & mask) == mask);
            step(1);
        end
        if (!keep) valid_m = valid_m & ~mask;
        check("handshake", 32'(ok), 32'd1);
    endtask

    // Entered 'off' cycles after the handshake edge; samples every line mid-bit, then waits for done.
    task automatic frame(input int g, input int nb, input int off, output samp_t s, output int lat);
        s = '1;
        step(N / 2 - off);
        lat = N / 2;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) begin
                step(N);
                lat += N;
            end
            s[i] = line;
        end
        while (!done[g] && lat < (nb + 2) * N) begin
            step(1);
            lat++;
        end
    endtask

    initial begin
        rnd_rst   = 1'b1;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        step(12);
        rnd_rst = 1'b0;
        while (rnd_run) begin
            step(1);
            rnd_data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rnd_valid = ~rnd_valid;
            rnd_rst = ($urandom_range(0, 2999) == 0);
        end
    end

    always @(negedge clk) if (done[3]) rnd_frames++;

    initial begin
        samp_t s;
        int    lat;
        rst_m   = '1;
        valid_m = '0;
        data_m  = '0;

        // Reset state, during and after
        step(1);
        mon_en = 1'b1;
        step(9);
        check("t1.in_reset", 32'({line[0], tx_ready[0], busy[0], done[0]}), 32'hC);
        rst_m = '0;
        step(3);
        check("t1.after_reset", 32'({line[0], tx_ready[0], busy[0], done[0]}), 32'hC);

        // Single byte 0x82
        handshake(3'b001, 8'h82, 1'b0);
        frame(0, 10, 0, s, lat);
        check("t2.bits", 32'(col(s, 0)), 32'({2'b11, 1'b1, 8'h82, 1'b0}));
        check("t2.latency", 32'(lat), 32'(10 * N));
        check("t2.done", 32'(done[0]), 32'd1);

        // Back-to-back 0x55 then 0xAA with tx_valid held
        handshake(3'b001, 8'h55, 1'b1);
        data_m = 8'hAA;
        frame(0, 10, 0, s, lat);
        check("t3.bits1", 32'(col(s, 0)), 32'({2'b11, 1'b1, 8'h55, 1'b0}));
        check("t3.latency1", 32'(lat), 32'(10 * N));
        check("t3.ready_at_done", 32'(tx_ready[0]), 32'd1);
        step(1);
        valid_m[0] = 1'b0;
        check("t3.start_gap", 32'({line[0], busy[0]}), 32'b01);
        frame(0, 10, 0, s, lat);
        check("t3.bits2", 32'(col(s, 0)), 32'({2'b11, 1'b1, 8'hAA, 1'b0}));
        check("t3.latency2", 32'(lat), 32'(10 * N));

        // Parity on 0x07: even instance and odd instance side by side
        step(2);
        handshake(3'b110, 8'h07, 1'b0);
        frame(1, 11, 0, s, lat);
        check("t4.even_bits", 32'(col(s, 1)), 32'({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}));
        check("t4.odd_bits", 32'(col(s, 2)), 32'({1'b1, 1'b1, 1'b0, 8'h07, 1'b0}));
        check("t4.latency", 32'(lat), 32'(11 * N));
        check("t4.odd_done", 32'(done[2]), 32'd1);

        // Abort during the 4th data bit, then a clean 0xA5
        step(2);
        handshake(3'b001, 8'hC3, 1'b0);
        step(4 * N + N / 2);
        check("t5.d3", 32'(line[0]), 32'd0);
        #1;
        rst_m[0] = 1'b1;
        #1;
        check("t5.abort", 32'({line[0], tx_ready[0], busy[0], done[0]}), 32'hC);
        step(3);
        rst_m[0] = 1'b0;
        step(2);
        handshake(3'b001, 8'hA5, 1'b0);
        frame(0, 10, 0, s, lat);
        check("t5.bits", 32'(col(s, 0)), 32'({2'b11, 1'b1, 8'hA5, 1'b0}));
        check("t5.latency", 32'(lat), 32'(10 * N));

        // tx_valid pulse with 0xFF while 0x3C is on the line
        step(2);
        handshake(3'b001, 8'h3C, 1'b0);
        data_m     = 8'hFF;
        valid_m[0] = 1'b1;
        step(5);
        check("t6.ready_low", 32'({tx_ready[0], busy[0]}), 32'b01);
        valid_m[0] = 1'b0;
        frame(0, 10, 5, s, lat);
        check("t6.bits", 32'(col(s, 0)), 32'({2'b11, 1'b1, 8'h3C, 1'b0}));
        check("t6.latency", 32'(lat), 32'(10 * N));
        step(2 * N);
        check("t6.idle", 32'({line[0], tx_ready[0], busy[0]}), 32'b110);

        rnd_run = 1'b0;
        check("rnd.frames_seen", 32'(rnd_frames > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter. It is the upstream counterpart of UART_rx and drives the Rs232 line that UART_rx samples.
- Accepts one byte per valid/ready handshake.
- Serialises it LSB-first as start bit, data bits, optional parity bit, then stop bit(s).
- Uses the same bit timing as UART_rx: 5 MHz clk, 4800 baud, 1042 clocks per bit.

Parameters:
- CLKS_PER_BIT, 1042: clk cycles per serial bit; must be >= 2.
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte this cycle.
- Rs232_tx  out  1  serial line; idle level is high.
- busy  out  1  a frame is in progress.
- done_flag  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (asynchronous, immediate):
  - Rs232_tx=1, tx_ready=1, busy=0, done_flag=0.
  - FSM goes to IDLE; the bit counter and baud counter clear.
- All outputs are registered. Rs232_tx comes straight from a flop, so the line is glitch-free.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, Rs232_tx=1.
  - Handshake = tx_valid & tx_ready at a rising edge. On handshake, latch tx_data into the shift register and enter START.
  - Rs232_tx=0 from the next cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width is $clog2(CLKS_PER_BIT).
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The bit advances when count==CLKS_PER_BIT-1, and the counter wraps to 0.
- START: drive 0 for one bit time, then go to DATA.
- DATA:
  - Drive shift_reg[0], shifting right after each bit.
  - After DATA_BITS bits, go to PARITY if PARITY_EN, otherwise to STOP.
- PARITY:
  - Drive the XOR of the latched data for even parity; drive its inverse for odd.
  - Parity is computed from the latched copy, not from live tx_data.
- STOP:
  - Drive 1 for STOP_BITS bit times.
  - On the final cycle of the last stop bit, pulse done_flag for 1 cycle and return to IDLE.
- Frame duration: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the cycle after handshake.
- tx_ready and busy:
  - tx_ready=0 in every state except IDLE.
  - busy equals the inverse of tx_ready.
- tx_data and tx_valid are ignored while busy; changes to tx_data mid-frame have no effect.
- Back-to-back frames:
  - tx_ready rises in the same cycle done_flag pulses.
  - If tx_valid is already high then, the handshake happens in that cycle and the next start bit follows with no extra idle bit.
  - The only gap between frames is the stop bits plus a 1-cycle handshake.
- Reset mid-frame: the frame is aborted, the line goes to 1 immediately, and no done_flag is produced. The next handshake after reset works normally.
- Simultaneous rst and tx_valid: reset wins and nothing is latched.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - CLK_HZ = 5_000_000 and BAUD = 4800.
  - Derived CLKS_PER_BIT = 1042, shared with UART_rx.
  - Parity-select constants.
- One natural sub-module: uart_baud_gen.
  - Parameterised bit-period counter with clear input and tick output.
  - Reusable by UART_rx.
- Shift register, bit counter and FSM stay in uart_tx.

Test Plan:
1. Reset: pulse rst high for 10 cycles with tx_valid=0 -> Rs232_tx=1, tx_ready=1, busy=0, done_flag=0 throughout and after.
2. Single byte 0x82, default parameters:
   - Line sequence 0,0,1,0,0,0,0,0,1,1, each bit 1042 cycles.
   - done_flag pulses exactly 10*1042 cycles after handshake.
   - In loopback to UART_rx: rx_data=0x82 and its done_flag asserts.
3. Back-to-back 0x55 then 0xAA with tx_valid held high:
   - Second start bit begins 1 cycle after the first done_flag.
   - Bits are 1,0,1,0,1,0,1,0 then 0,1,0,1,0,1,0,1; no idle bit between frames.
4. Parity, PARITY_EN=1, send 0x07 -> parity bit is 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame is 11*1042 cycles.
5. Abort: assert rst during the 4th data bit -> Rs232_tx=1 within the same cycle, no done_flag. A following send of 0xA5 completes correctly.
6. Busy protection: during frame 0x3C, pulse tx_valid with tx_data=0xFF -> tx_ready stays 0, the transmitted bits remain those of 0x3C, and no second frame follows.
